commit_trace_buffer: RTL and testbench

- Synthesizable successor to the bench-side commit monitor of the 16-bit pipelined cpu.
- Sits beside the cpu and samples writeback/memory-stage commit signals every cycle.
- Packs each committing cycle into one trace record and buffers records in a parametrised FIFO with a valid/ready drain port.
- Keeps cycle, instruction and dropped-record counters, and freezes capture on halt or on a cycle limit.

---
 rtl/commit_trace_buffer.sv | 167 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit trace capture with record FIFO and counters

// Record queue: pointers carry one extra wrap bit so full and empty differ.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_tvalid = !empty;
    assign pop      = m_tvalid && m_tready;
    // A full queue still takes a record when the head leaves in the same cycle.
    assign s_tready = !full || pop;
    assign push     = s_tvalid && s_tready;
    assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end
endmodule

module commit_trace_buffer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = 4,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000,
    parameter int REC_W       = 4 + REG_AW + DATA_W + 2 * ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] reg_id,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [REC_W-1:0]  rec_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              halted,
    output logic              timeout,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              active;
    logic              is_event;
    logic              counts_inst;
    logic              limit_hit;
    logic              push_ready;
    logic [REG_AW-1:0] f_reg_id;
    logic [DATA_W-1:0] f_reg_data;
    logic [ADDR_W-1:0] f_mem_addr;
    logic [DATA_W-1:0] f_mem_data;
    logic [REC_W-1:0]  record;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Capture only happens in RUN with enable held; dropping enable pauses.
    assign active      = (state == RUN) && cap_en;
    assign is_event    = active && (reg_we || mem_re || mem_we || hlt);
    assign counts_inst = active && (hlt || reg_we || mem_we);
    // The cycle whose increment reaches the limit is the last RUN cycle.
    assign limit_hit   = (cycle_count == CNT_W'(CYCLE_LIMIT - 1));

    assign f_reg_id   = reg_we ? reg_id : '0;
    assign f_reg_data = reg_we ? reg_data : '0;
    assign f_mem_addr = (mem_re || mem_we) ? mem_addr : '0;
    assign f_mem_data = mem_we ? mem_wdata : (mem_re ? mem_rdata : '0);
    assign record     = {hlt, mem_we, mem_re, reg_we, f_reg_id, f_reg_data,
                         pc, f_mem_addr, f_mem_data};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cap_en) state_next = RUN;
            RUN: begin
                if (!cap_en)               state_next = IDLE;
                else if (hlt || limit_hit) state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (active)                   cycle_count <= sat_inc(cycle_count);
            if (counts_inst)              inst_count  <= sat_inc(inst_count);
            if (is_event && !push_ready) begin
                drop_count <= sat_inc(drop_count);
                overflow   <= 1'b1;
            end
            if (active && hlt)            halted  <= 1'b1;
            if (active && limit_hit)      timeout <= 1'b1;
        end
    end

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (record),
        .s_tvalid (is_event),
        .s_tready (push_ready),
        .m_tdata  (rec_data),
        .m_tvalid (rec_valid),
        .m_tready (rec_ready)
    );
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench for commit_trace_buffer

module tb_commit_trace_buffer;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int REG_AW      = 4;
    localparam int DEPTH       = 16;
    localparam int CNT_W       = 32;
    localparam int CYCLE_LIMIT = 50;
    localparam int REC_W       = 72;

    logic              clk;
    logic              rst;
    logic              cap_en;
    logic [ADDR_W-1:0] pc;
    logic              reg_we;
    logic [REG_AW-1:0] reg_id;
    logic [DATA_W-1:0] reg_data;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              hlt;
    logic              rec_valid;
    logic              rec_ready;
    logic [REC_W-1:0]  rec_data;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  drop_count;
    logic              halted;
    logic              timeout;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [REC_W-1:0] exp_q[$];

    commit_trace_buffer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .REG_AW      (REG_AW),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (cap_en),
        .pc          (pc),
        .reg_we      (reg_we),
        .reg_id      (reg_id),
        .reg_data    (reg_data),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .hlt         (hlt),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_data    (rec_data),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .drop_count  (drop_count),
        .halted      (halted),
        .timeout     (timeout),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted head record is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got %h expected none", rec_data);
            end else begin
                logic [REC_W-1:0] e;
                e = exp_q.pop_front();
                if (rec_data !== e) begin
                    errors++;
                    $display("FAIL record: got %h expected %h", rec_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input logic h, input logic mw, input logic mr,
                                            input logic rw, input logic [3:0] id,
                                            input logic [15:0] rd, input logic [15:0] p,
                                            input logic [15:0] a, input logic [15:0] md);
        return {h, mw, mr, rw, id, rd, p, a, md};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        pc = '0; reg_we = 0; reg_id = '0; reg_data = '0; mem_re = 0; mem_we = 0;
        mem_addr = '0; mem_wdata = '0; mem_rdata = '0; hlt = 0;
    endtask

    task automatic ev(input logic rw, input logic [3:0] id, input logic [15:0] rd,
                      input logic mr, input logic mw, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rdd,
                      input logic h, input logic [15:0] p);
        reg_we = rw; reg_id = id; reg_data = rd; mem_re = mr; mem_we = mw;
        mem_addr = a; mem_wdata = wd; mem_rdata = rdd; hlt = h; pc = p;
        tick();
        clr_ev();
    endtask

    task automatic do_reset();
        rst = 1;
        exp_q.delete();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || rec_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_done", {63'd0, (exp_q.size() == 0 && !rec_valid)}, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rec_valid"}, {63'd0, rec_valid}, 64'd0);
        chk({tag, "_rec_data"}, rec_data[63:0], 64'd0);
        chk({tag, "_rec_data_hi"}, {56'd0, rec_data[71:64]}, 64'd0);
        chk({tag, "_cycle"}, {32'd0, cycle_count}, 64'd0);
        chk({tag, "_inst"}, {32'd0, inst_count}, 64'd0);
        chk({tag, "_drop"}, {32'd0, drop_count}, 64'd0);
        chk({tag, "_flags"}, {61'd0, halted, timeout, overflow}, 64'd0);
    endtask

    initial begin
        rst = 1; cap_en = 0; rec_ready = 0;
        clr_ev();
        do_reset();
        chk_all_zero("reset");

        // Three register writes, then a combined reg write + load.
        rec_ready = 1; cap_en = 1;
        tick();
        chk("idle_to_run_no_valid", {63'd0, rec_valid}, 64'd0);
        exp_q.push_back(mk(0, 0, 0, 1, 4'd1, 16'h0011, 16'h0010, 16'h0, 16'h0));
        ev(1, 4'd1, 16'h0011, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0010);
        chk("latency_one", {63'd0, rec_valid}, 64'd1);
        exp_q.push_back(mk(0, 0, 0, 1, 4'd2, 16'h0022, 16'h0011, 16'h0, 16'h0));
        ev(1, 4'd2, 16'h0022, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0011);
        exp_q.push_back(mk(0, 0, 0, 1, 4'd3, 16'h0033, 16'h0012, 16'h0, 16'h0));
        ev(1, 4'd3, 16'h0033, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0012);
        chk("inst_after_3", {32'd0, inst_count}, 64'd3);
        exp_q.push_back(mk(0, 0, 1, 1, 4'd4, 16'hBEEF, 16'h0013, 16'h0040, 16'h1234));
        ev(1, 4'd4, 16'hBEEF, 1, 0, 16'h0040, 16'h5555, 16'h1234, 0, 16'h0013);
        tick();
        chk("inst_after_4", {32'd0, inst_count}, 64'd4);
        chk("cycle_after_a", {32'd0, cycle_count}, 64'd5);
        chk("queue_empty_a", {32'd0, exp_q.size()}, 64'd0);
        cap_en = 0;
        tick();
        chk("no_valid_a", {63'd0, rec_valid}, 64'd0);

        // Overflow: 20 writes into a 16-deep queue with no consumer.
        rec_ready = 0; cap_en = 1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i < 16)
                exp_q.push_back(mk(0, 0, 0, 1, 4'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i),
                                   16'h0, 16'h0));
            ev(1, 4'(i), 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0200 + 16'(i));
        end
        chk("drop_4", {32'd0, drop_count}, 64'd4);
        chk("overflow_set", {63'd0, overflow}, 64'd1);
        chk("inst_24", {32'd0, inst_count}, 64'd24);
        // Full queue with simultaneous pop: the push must be accepted.
        rec_ready = 1;
        exp_q.push_back(mk(0, 0, 0, 1, 4'd5, 16'h5555, 16'h0300, 16'h0, 16'h0));
        ev(1, 4'd5, 16'h5555, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0300);
        chk("drop_unchanged", {32'd0, drop_count}, 64'd4);
        cap_en = 0;
        drain(40);
        chk("inst_25", {32'd0, inst_count}, 64'd25);

        // Store, halt, then ignored writes.
        do_reset();
        rec_ready = 1; cap_en = 1;
        tick();
        exp_q.push_back(mk(0, 1, 0, 0, 4'd0, 16'h0, 16'h0020, 16'h0100, 16'hAAAA));
        ev(0, 4'd9, 16'h9999, 0, 1, 16'h0100, 16'hAAAA, 16'h7777, 0, 16'h0020);
        exp_q.push_back(mk(1, 0, 0, 0, 4'd0, 16'h0, 16'h0021, 16'h0, 16'h0));
        ev(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 16'h0021);
        chk("halted_set", {63'd0, halted}, 64'd1);
        for (int i = 0; i < 5; i++)
            ev(1, 4'(i), 16'hDEAD, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0030 + 16'(i));
        chk("halt_inst_2", {32'd0, inst_count}, 64'd2);
        chk("halt_cycle_frozen", {32'd0, cycle_count}, 64'd2);
        chk("halt_no_timeout", {63'd0, timeout}, 64'd0);
        drain(10);

        // Cycle limit of 50 with no halt.
        do_reset();
        rec_ready = 1; cap_en = 1;
        tick();
        repeat (48) tick();
        exp_q.push_back(mk(0, 0, 0, 1, 4'd7, 16'h0707, 16'h0400, 16'h0, 16'h0));
        ev(1, 4'd7, 16'h0707, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0400);
        chk("cycle_49", {32'd0, cycle_count}, 64'd49);
        chk("no_timeout_49", {63'd0, timeout}, 64'd0);
        exp_q.push_back(mk(0, 0, 0, 1, 4'd8, 16'h0808, 16'h0401, 16'h0, 16'h0));
        ev(1, 4'd8, 16'h0808, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0401);
        chk("timeout_set", {63'd0, timeout}, 64'd1);
        chk("cycle_50", {32'd0, cycle_count}, 64'd50);
        ev(1, 4'd9, 16'h0909, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0402);
        chk("cycle_50_frozen", {32'd0, cycle_count}, 64'd50);
        chk("timeout_inst_2", {32'd0, inst_count}, 64'd2);
        drain(10);

        // Reset in the middle of a run discards everything.
        do_reset();
        rec_ready = 0; cap_en = 1;
        tick();
        for (int i = 0; i < 3; i++)
            ev(1, 4'(i), 16'h1111, 1, 0, 16'h0050, 16'h0, 16'h2222, 0, 16'h0500 + 16'(i));
        chk("pre_rst_valid", {63'd0, rec_valid}, 64'd1);
        chk("pre_rst_inst", {32'd0, inst_count}, 64'd3);
        rst = 1;
        exp_q.delete();
        tick();
        rst = 0;
        chk_all_zero("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
